// File: rtl/cpu_pkg.sv
// Shared CPU constants for the general register file and its scoreboard.
// Optional trace output is enabled by defining GRF_TRACE_EN.
package cpu_pkg;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;
    localparam int         NUM_GPR  = 32;
    localparam int         DATA_W   = 32;

    // Byte-exact writeback trace line: PC, destination register, data.
    localparam string      TRACE_FMT = "@%h: $%d <= %h";
endpackage

// File: rtl/grf_scoreboard_if.sv
// Writeback, decode-read and issue/flush signals of the register file.
// master = pipeline side driving requests, slave = register file.
interface grf_scoreboard_if;
    import cpu_pkg::*;

    logic              wb_en;
    logic [4:0]        WriteAddr;
    logic [DATA_W-1:0] RegData;
    logic [DATA_W-1:0] wb_pc;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              issue_en;
    logic [4:0]        issue_addr;
    logic              flush;
    logic              rs_busy;
    logic              rt_busy;
    logic              sb_overflow;

    modport master (
        output wb_en, WriteAddr, RegData, wb_pc, rs_addr, rt_addr,
               issue_en, issue_addr, flush,
        input  rs_data, rt_data, rs_busy, rt_busy, sb_overflow
    );

    modport slave (
        input  wb_en, WriteAddr, RegData, wb_pc, rs_addr, rt_addr,
               issue_en, issue_addr, flush,
        output rs_data, rt_data, rs_busy, rt_busy, sb_overflow
    );
endinterface

// File: rtl/grf_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// ovf_o pulses when an increment is refused because the counter is full.
module sb_counter #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_eff;

    // Next count: clear wins, inc+dec cancel, no underflow, saturate at max.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_o   = 1'b0;
        dec_eff = dec && (cnt_q != '0);
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec_eff) begin
            if (cnt_q == CNT_W'(MAX_PENDING)) begin
                ovf_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_eff && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/grf_scoreboard.sv
// 32x32 register file with write-first bypass and a per-register
// pending-write scoreboard producing decode stall flags.
// Define GRF_TRACE_EN to print one trace line per architectural write.
module grf_scoreboard #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic            clk,
    input  logic            reset,
    grf_scoreboard_if.slave bus
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_GPR];
    logic [CNT_W-1:0]  cnt    [NUM_GPR];
    logic [NUM_GPR-1:0] ovf_pulse;
    logic              overflow_q;
    logic              wb_write;
    logic              issue_ok;
    logic              hit_rs;
    logic              hit_rt;

    assign wb_write = bus.wb_en && (bus.WriteAddr != REG_ZERO);
    assign issue_ok = bus.issue_en && !bus.flush;

    // $0 has no counter: it is never pending.
    assign cnt[0]       = '0;
    assign ovf_pulse[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_GPR; gi++) begin : g_cnt
            sb_counter #(
                .MAX_PENDING(MAX_PENDING),
                .CNT_W      (CNT_W)
            ) u_cnt (
                .clk  (clk),
                .reset(reset),
                .inc  (issue_ok && (bus.issue_addr == 5'(gi))),
                .dec  (bus.wb_en && (bus.WriteAddr == 5'(gi))),
                .clr  (bus.flush),
                .cnt_o(cnt[gi]),
                .ovf_o(ovf_pulse[gi])
            );
        end
    endgenerate

    // Architectural register array; a WB still lands during a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_write) begin
            regs_q[bus.WriteAddr] <= bus.RegData;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (|ovf_pulse) begin
            overflow_q <= 1'b1;
        end
    end

    assign hit_rs = bus.wb_en && (bus.WriteAddr == bus.rs_addr);
    assign hit_rt = bus.wb_en && (bus.WriteAddr == bus.rt_addr);

    // Read ports with write-first bypass; $0 is hard-wired to zero.
    always_comb begin
        bus.rs_data = regs_q[bus.rs_addr];
        bus.rt_data = regs_q[bus.rt_addr];
        if (hit_rs) bus.rs_data = bus.RegData;
        if (hit_rt) bus.rt_data = bus.RegData;
        if (bus.rs_addr == REG_ZERO) bus.rs_data = '0;
        if (bus.rt_addr == REG_ZERO) bus.rt_data = '0;
    end

    // Busy only if a write remains pending after any retirement this cycle.
    assign bus.rs_busy = (bus.rs_addr != REG_ZERO) && (cnt[bus.rs_addr] > CNT_W'(hit_rs));
    assign bus.rt_busy = (bus.rt_addr != REG_ZERO) && (cnt[bus.rt_addr] > CNT_W'(hit_rt));
    assign bus.sb_overflow = overflow_q;

`ifdef GRF_TRACE_EN
    // Trace of every committed architectural write.
    always_ff @(posedge clk) begin
        if (!reset && wb_write) begin
            $display(TRACE_FMT, bus.wb_pc, bus.WriteAddr, bus.RegData);
        end
    end
`else
    logic unused_wb_pc;
    assign unused_wb_pc = ^bus.wb_pc;
`endif
endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench: directed steps then random traffic, compared against
// a behavioural register-file/scoreboard model.
module tb_grf_scoreboard;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_scoreboard_if bus ();

    grf_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit wb,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (wb && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_busy(input logic [4:0] a, input bit wb, input logic [4:0] wa);
        int remain;
        remain = m_cnt[a] - ((wb && wa == a) ? 1 : 0);
        return (a != 0 && remain > 0) ? 32'd1 : 32'd0;
    endfunction

    // One clock cycle: drive, check combinational outputs, then advance model.
    task automatic step(input bit chk, input bit rst, input bit wb, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                        input bit iss, input logic [4:0] ia, input bit fl);
        @(negedge clk);
        reset          = rst;
        bus.wb_en      = wb;
        bus.WriteAddr  = wa;
        bus.RegData    = wd;
        bus.wb_pc      = $urandom;
        bus.rs_addr    = ra;
        bus.rt_addr    = rb;
        bus.issue_en   = iss;
        bus.issue_addr = ia;
        bus.flush      = fl;
        #1;
        if (chk) begin
            check("rs_data", bus.rs_data, m_read(ra, wb, wa, wd));
            check("rt_data", bus.rt_data, m_read(rb, wb, wa, wd));
            check("rs_busy", 32'(bus.rs_busy), m_busy(ra, wb, wa));
            check("rt_busy", 32'(bus.rt_busy), m_busy(rb, wb, wa));
            check("sb_overflow", 32'(bus.sb_overflow), 32'(m_ovf));
        end
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_cnt[r]  = 0;
            end
            m_ovf = 1'b0;
        end else begin
            if (wb && wa != 0) m_regs[wa] = wd;
            if (fl) begin
                for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            end else begin
                for (int r = 1; r < 32; r++) begin
                    bit inc, dec;
                    inc = iss && ia == r;
                    dec = wb && wa == r && m_cnt[r] > 0;
                    if (inc && !dec) begin
                        if (m_cnt[r] == MAXP) m_ovf = 1'b1;
                        else m_cnt[r]++;
                    end else if (dec && !inc) begin
                        m_cnt[r]--;
                    end
                end
            end
        end
        $display("cyc rst=%0b wb=%0b wa=%0d wd=%h ra=%0d rb=%0d iss=%0b ia=%0d fl=%0b rs=%h rt=%h",
                 rst, wb, wa, wd, ra, rb, iss, ia, fl, bus.rs_data, bus.rt_data);
    endtask

    initial begin
        reset = 1'b1;
        bus.wb_en = 0; bus.WriteAddr = 0; bus.RegData = 0; bus.wb_pc = 0;
        bus.rs_addr = 0; bus.rt_addr = 0; bus.issue_en = 0; bus.issue_addr = 0; bus.flush = 0;

        // Reset, then read back zeros
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5, 31, 0, 0, 0);
        check("reset_rs_data_lit", bus.rs_data, 32'd0);

        // Write with same-cycle bypass, then registered read
        step(1, 0, 1, 8, 32'hDEADBEEF, 8, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 8, 8, 0, 0, 0);
        check("bypass_hold_lit", bus.rs_data, 32'hDEADBEEF);

        // $0 protection
        step(1, 0, 1, 0, 32'h12345678, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Two issues to $9, two retirements
        step(1, 0, 0, 0, 0, 9, 9, 1, 9, 0);
        step(1, 0, 0, 0, 0, 9, 9, 1, 9, 0);
        step(1, 0, 1, 9, 32'h99, 9, 9, 0, 0, 0);
        check("sb9_busy_after_1wb", 32'(bus.rs_busy), 32'd1);
        step(1, 0, 1, 9, 32'h9A, 9, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 9, 0, 0, 0);

        // Simultaneous issue+WB on $10 with cnt=1
        step(1, 0, 0, 0, 0, 10, 10, 1, 10, 0);
        step(1, 0, 1, 10, 32'hA0, 10, 10, 1, 10, 0);
        step(1, 0, 0, 0, 0, 10, 10, 0, 0, 0);
        step(1, 0, 1, 10, 32'hA1, 10, 10, 0, 0, 0);

        // Overflow on $11
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 11, 0, 1, 11, 0);
        step(1, 0, 0, 0, 0, 11, 0, 0, 0, 0);
        check("overflow_lit", 32'(bus.sb_overflow), 32'd1);

        // Flush with simultaneous WB and ignored issue
        step(1, 0, 0, 0, 0, 12, 0, 1, 12, 0);
        step(1, 0, 0, 0, 0, 12, 0, 1, 12, 0);
        step(1, 0, 1, 12, 32'd7, 12, 11, 1, 12, 1);
        step(1, 0, 0, 0, 0, 12, 11, 0, 0, 0);
        check("flush_data_lit", bus.rs_data, 32'd7);

        // Random traffic over a small register window
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 500; n++) begin
            step(1, ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
